pipe_run_ctrl: RTL

PIPE_RUN_CTRL -- requirements
Module: pipe_run_ctrl

---
 rtl/pipe_run_ctrl_pkg.sv | 20 ++
 rtl/pipe_run_ctrl_sync_edge.sv | 49 ++++
 rtl/pipe_run_ctrl.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/pipe_run_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_run_ctrl_pkg
//
// Purpose : shared CPU package holding the run-control state encodings.
//           The datapath and debug tooling decode the 2-bit `state` output
//           of pipe_run_ctrl using these constants.
//
// Contents: ST_RUN  (0) - pipeline free-running
//           ST_HALT (1) - pipeline frozen, waiting for a step or debug_en=0
//           ST_STEP (2) - pipeline running a fixed-length step burst
//           ST_BRK  (3) - pipeline frozen on a breakpoint fetch address
// -----------------------------------------------------------------------------
package pipe_run_ctrl_pkg;

    localparam logic [1:0] ST_RUN  = 2'd0;
    localparam logic [1:0] ST_HALT = 2'd1;
    localparam logic [1:0] ST_STEP = 2'd2;
    localparam logic [1:0] ST_BRK  = 2'd3;

endpackage : pipe_run_ctrl_pkg

// File: rtl/pipe_run_ctrl_sync_edge.sv
// -----------------------------------------------------------------------------
// sync_edge
//
// Purpose : brings an asynchronous, already-debounced level into the clock
//           domain through a flop chain and flags its rising edge.
//
// Ports   : clock - sole clock, rising edge
//           reset - synchronous active-high reset, clears every flop
//           d     - asynchronous input level
//           q     - synchronized level (last synchronizer stage)
//           rise  - 1 for exactly one cycle when q goes 0 -> 1
//
// Timing  : a 1 on d first sampled at edge n appears on q after edge
//           n+SYNC_STAGES-1, so rise is seen by logic clocked at edge
//           n+SYNC_STAGES.
// -----------------------------------------------------------------------------
module sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q,
    output logic rise
);

    // Fewer than two stages gives no metastability settling time.
    localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour; blocking assignments here
    // would collapse the chain into a single flop.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign q    = sync_q[STAGES-1];
    assign rise = sync_q[STAGES-1] & ~prev_q;

endmodule : sync_edge

// File: rtl/pipe_run_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_run_ctrl
//
// Purpose : run / halt / single-step / breakpoint controller for a 5-stage
//           pipeline. It produces one clock enable that gates every
//           architectural update in the pipeline (PC, stage registers,
//           register-file and data-memory writes).
//
// Ports   : clock        - sole clock, rising edge
//           reset        - synchronous active-high reset
//           debug_en     - 1 = halt/step mode, 0 = free run
//           debug_step   - asynchronous debounced step button
//           bp_en        - breakpoint enable
//           bp_pc        - breakpoint fetch address
//           if_pc        - current fetch PC from the pipeline
//           burst_len    - pipeline cycles per step request (0 acts as 1)
//           pipe_ce      - pipeline clock enable
//           halted       - 1 in HALT or BRK
//           bp_hit       - 1 in BRK
//           state        - current state encoding (see pipe_run_ctrl_pkg)
//           cycle_count  - number of cycles with pipe_ce=1 since reset
// -----------------------------------------------------------------------------
module pipe_run_ctrl
    import pipe_run_ctrl_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             debug_en,
    input  logic             debug_step,
    input  logic             bp_en,
    input  logic [31:0]      bp_pc,
    input  logic [31:0]      if_pc,
    input  logic [7:0]       burst_len,
    output logic             pipe_ce,
    output logic             halted,
    output logic             bp_hit,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] cycle_count
);

    logic [1:0]       state_q,       state_d;
    logic [7:0]       burst_q,       burst_d;
    logic [CNT_W-1:0] cycle_count_q, cycle_count_d;

    logic       bp_match;
    logic       step_level;
    logic       step_rise;
    logic       step_edge;
    logic [7:0] burst_load;

    // -------------------------------------------------------------------------
    // Step button synchronizer and edge detector
    // -------------------------------------------------------------------------
    sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_step_sync (
        .clock (clock),
        .reset (reset),
        .d     (debug_step),
        .q     (step_level),
        .rise  (step_rise)
    );

    // A rise is only honoured while the synchronized level is high.
    assign step_edge = step_rise & step_level;

    // -------------------------------------------------------------------------
    // Breakpoint compare: full 32-bit match on the address being fetched.
    // It stays combinational so the instruction at bp_pc is frozen in IF in
    // the very cycle it is presented.
    // -------------------------------------------------------------------------
    assign bp_match = bp_en & (if_pc == bp_pc);

    // A zero-length burst still advances the pipeline by one cycle.
    assign burst_load = (burst_len == 8'd0) ? 8'd1 : burst_len;

    // -------------------------------------------------------------------------
    // Pipeline enable. Forced low while reset is asserted so an aborted burst
    // cannot leak one more pulse into the reset cycle.
    // -------------------------------------------------------------------------
    always_comb begin
        pipe_ce = 1'b0;
        if (!reset) begin
            unique case (state_q)
                ST_STEP: pipe_ce = 1'b1;
                ST_RUN:  pipe_ce = ~bp_match & ~debug_en;
                default: pipe_ce = 1'b0;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every variable assigned in this block gets a default on entry, so
    // paths that do not mention it hold the register value instead of
    // inferring a latch.
    always_comb begin
        state_d = state_q;
        burst_d = burst_q;

        unique case (state_q)
            ST_RUN: begin
                // Entering debug mode wins over a simultaneous breakpoint.
                if (debug_en) begin
                    state_d = ST_HALT;
                end else if (bp_match) begin
                    state_d = ST_BRK;
                end
            end

            ST_HALT: begin
                // Leaving debug mode wins over a simultaneous step request.
                if (!debug_en) begin
                    state_d = ST_RUN;
                end else if (step_edge) begin
                    state_d = ST_STEP;
                    burst_d = burst_load;
                end
            end

            ST_STEP: begin
                // bp_match, debug_en and step_edge are ignored mid-burst; a
                // stray zero count still terminates instead of wrapping.
                if (burst_q <= 8'd1) begin
                    state_d = debug_en ? ST_HALT : ST_RUN;
                    burst_d = 8'd0;
                end else begin
                    burst_d = burst_q - 8'd1;
                end
            end

            ST_BRK: begin
                // A step moves the pipeline off the breakpoint address even
                // though bp_match is still true.
                if (step_edge) begin
                    state_d = ST_STEP;
                    burst_d = burst_load;
                end else if (!bp_en) begin
                    state_d = debug_en ? ST_HALT : ST_RUN;
                end
            end

            default: begin
                state_d = ST_HALT;
            end
        endcase
    end

    // Free-running count of enabled cycles, wrapping naturally at all-ones.
    assign cycle_count_d = pipe_ce ? (cycle_count_q + CNT_W'(1)) : cycle_count_q;

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_HALT;
            burst_q       <= 8'd0;
            cycle_count_q <= '0;
        end else begin
            state_q       <= state_d;
            burst_q       <= burst_d;
            cycle_count_q <= cycle_count_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign state       = state_q;
    assign halted      = (state_q == ST_HALT) | (state_q == ST_BRK);
    assign bp_hit      = (state_q == ST_BRK);
    assign cycle_count = cycle_count_q;

endmodule : pipe_run_ctrl
